// File: rtl/control_partida_if.sv
// Move handshake between the game sequencer and whoever issues moves.
interface control_partida_if;
  logic       mov_valid;
  logic       mov_ready;
  logic [1:0] mov_tipo;
  logic [2:0] pos_x;
  logic [2:0] pos_y;

  modport master (
    output mov_valid,
    output mov_tipo,
    output pos_x,
    output pos_y,
    input  mov_ready
  );

  modport slave (
    input  mov_valid,
    input  mov_tipo,
    input  pos_x,
    input  pos_y,
    output mov_ready
  );
endinterface

// File: rtl/control_partida.sv
// Minesweeper game sequencer for an 8x8 board: bomb placement, move handling,
// stack-based flood-fill reveal and win/loss tracking. Cell index is {x, y}.
module control_partida #(
  parameter int unsigned MAX_BOMBAS   = 16,
  parameter logic [7:0]  LFSR_SEMILLA = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [5:0]              num_bombas,
  control_partida_if.slave        mov,
  output logic [2:0]              perim_x,
  output logic [2:0]              perim_y,
  input  logic [3:0]              perim_cnt,
  output logic [63:0]             bombas_out,
  output logic [63:0]             celda_revelada,
  output logic [63:0]             celda_bandera,
  output logic [6:0]              casillas_libres,
  output logic [1:0]              estado_juego,
  output logic                    busy
);

  typedef enum logic [2:0] {
    StIdle,
    StColocar,
    StEspera,
    StPop,
    StVecinos,
    StFin
  } state_e;

  localparam logic [1:0] EstInactivo = 2'd0;
  localparam logic [1:0] EstJugando  = 2'd1;
  localparam logic [1:0] EstGano     = 2'd2;
  localparam logic [1:0] EstPerdio   = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [63:0] bombas_q, bombas_d;
  logic [63:0] rev_q, rev_d;
  logic [63:0] flag_q, flag_d;
  logic [63:0] en_pila_q, en_pila_d;
  logic [6:0]  libres_q, libres_d;
  logic [1:0]  estado_q, estado_d;
  logic [5:0]  n_q, n_d;
  logic [5:0]  colocadas_q, colocadas_d;
  logic [6:0]  sp_q, sp_d;
  logic [5:0]  centro_q, centro_d;
  logic [2:0]  k_q, k_d;

  // Flood-fill stack; depth 64 is enough because en_pila keeps entries unique.
  logic [5:0]  pila_q [64];
  logic        push_en;
  logic [5:0]  push_dat;
  logic [5:0]  top_ptr;
  logic [5:0]  top_idx;

  logic [5:0]  n_clamp;
  logic [5:0]  cand;
  logic [5:0]  mov_idx;
  logic        mov_ready_s;

  // Neighbour walk: offset codes 0/1/2 stand for -1/0/+1.
  logic [1:0]  dx_c, dy_c;
  logic [2:0]  nb_x, nb_y;
  logic [5:0]  nb_idx;
  logic        nb_ok;

  assign cand     = lfsr_q[5:0];
  assign mov_idx  = {mov.pos_x, mov.pos_y};
  assign top_ptr  = sp_q[5:0] - 6'd1;
  assign top_idx  = pila_q[top_ptr];
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign mov.mov_ready   = mov_ready_s;
  assign bombas_out      = bombas_q;
  assign celda_revelada  = rev_q;
  assign celda_bandera   = flag_q;
  assign casillas_libres = libres_q;
  assign estado_juego    = estado_q;

  // Clamp the requested bomb count into 1..MAX_BOMBAS.
  always_comb begin
    n_clamp = num_bombas;
    if (num_bombas == 6'd0) begin
      n_clamp = 6'd1;
    end else if (32'(num_bombas) > MAX_BOMBAS) begin
      n_clamp = 6'(MAX_BOMBAS);
    end
  end

  // Decode neighbour k (row-major, centre skipped) and its bounds check.
  always_comb begin
    dx_c = 2'd1;
    dy_c = 2'd1;
    unique case (k_q)
      3'd0: begin dx_c = 2'd0; dy_c = 2'd0; end
      3'd1: begin dx_c = 2'd0; dy_c = 2'd1; end
      3'd2: begin dx_c = 2'd0; dy_c = 2'd2; end
      3'd3: begin dx_c = 2'd1; dy_c = 2'd0; end
      3'd4: begin dx_c = 2'd1; dy_c = 2'd2; end
      3'd5: begin dx_c = 2'd2; dy_c = 2'd0; end
      3'd6: begin dx_c = 2'd2; dy_c = 2'd1; end
      3'd7: begin dx_c = 2'd2; dy_c = 2'd2; end
    endcase
    nb_x   = centro_q[5:3] + {1'b0, dx_c} - 3'd1;
    nb_y   = centro_q[2:0] + {1'b0, dy_c} - 3'd1;
    nb_idx = {nb_x, nb_y};
    nb_ok  = !((dx_c == 2'd0) && (centro_q[5:3] == 3'd0)) &&
             !((dx_c == 2'd2) && (centro_q[5:3] == 3'd7)) &&
             !((dy_c == 2'd0) && (centro_q[2:0] == 3'd0)) &&
             !((dy_c == 2'd2) && (centro_q[2:0] == 3'd7));
  end

  // Next-state, datapath updates and outputs of the game FSM.
  always_comb begin
    state_d     = state_q;
    bombas_d    = bombas_q;
    rev_d       = rev_q;
    flag_d      = flag_q;
    en_pila_d   = en_pila_q;
    libres_d    = libres_q;
    estado_d    = estado_q;
    n_d         = n_q;
    colocadas_d = colocadas_q;
    sp_d        = sp_q;
    centro_d    = centro_q;
    k_d         = k_q;
    push_en     = 1'b0;
    push_dat    = '0;
    perim_x     = '0;
    perim_y     = '0;
    mov_ready_s = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      StIdle: begin
      end

      StColocar: begin
        busy = 1'b1;
        if (!bombas_q[cand]) begin
          bombas_d[cand] = 1'b1;
          colocadas_d    = colocadas_q + 6'd1;
        end
        if (colocadas_d == n_q) begin
          libres_d = 7'd64 - {1'b0, n_q};
          state_d  = StEspera;
        end
      end

      StEspera: begin
        mov_ready_s = 1'b1;
        if (mov.mov_valid) begin
          case (mov.mov_tipo)
            2'd2: begin
              if (!rev_q[mov_idx]) begin
                flag_d[mov_idx] = !flag_q[mov_idx];
              end
            end
            2'd1: begin
              if (!flag_q[mov_idx] && !rev_q[mov_idx]) begin
                if (bombas_q[mov_idx]) begin
                  rev_d[mov_idx] = 1'b1;
                  estado_d       = EstPerdio;
                  state_d        = StFin;
                end else begin
                  push_en            = 1'b1;
                  push_dat           = mov_idx;
                  sp_d               = sp_q + 7'd1;
                  en_pila_d[mov_idx] = 1'b1;
                  state_d            = StPop;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end

      StPop: begin
        busy = 1'b1;
        if (sp_q == 7'd0) begin
          en_pila_d = '0;
          if (libres_q == 7'd0) begin
            estado_d = EstGano;
            state_d  = StFin;
          end else begin
            state_d = StEspera;
          end
        end else begin
          sp_d    = sp_q - 7'd1;
          perim_x = top_idx[5:3];
          perim_y = top_idx[2:0];
          if (!flag_q[top_idx]) begin
            rev_d[top_idx] = 1'b1;
            libres_d       = libres_q - 7'd1;
            if (perim_cnt == 4'd0) begin
              centro_d = top_idx;
              k_d      = 3'd0;
              state_d  = StVecinos;
            end
          end
        end
      end

      StVecinos: begin
        busy = 1'b1;
        if (nb_ok && !rev_q[nb_idx] && !flag_q[nb_idx] && !en_pila_q[nb_idx]) begin
          push_en           = 1'b1;
          push_dat          = nb_idx;
          sp_d              = sp_q + 7'd1;
          en_pila_d[nb_idx] = 1'b1;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = StPop;
        end
      end

      StFin: begin
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A new game overrides whatever the current state decided, except while placing.
    if (start && (state_q != StColocar)) begin
      bombas_d    = '0;
      rev_d       = '0;
      flag_d      = '0;
      en_pila_d   = '0;
      sp_d        = '0;
      push_en     = 1'b0;
      libres_d    = '0;
      n_d         = n_clamp;
      colocadas_d = '0;
      estado_d    = EstJugando;
      state_d     = StColocar;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEMILLA;
      bombas_q    <= '0;
      rev_q       <= '0;
      flag_q      <= '0;
      en_pila_q   <= '0;
      libres_q    <= '0;
      estado_q    <= EstInactivo;
      n_q         <= 6'd1;
      colocadas_q <= '0;
      sp_q        <= '0;
      centro_q    <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      bombas_q    <= bombas_d;
      rev_q       <= rev_d;
      flag_q      <= flag_d;
      en_pila_q   <= en_pila_d;
      libres_q    <= libres_d;
      estado_q    <= estado_d;
      n_q         <= n_d;
      colocadas_q <= colocadas_d;
      sp_q        <= sp_d;
      centro_q    <= centro_d;
      k_q         <= k_d;
    end
  end

  // Stack storage; contents are don't-care whenever the pointer says empty.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      pila_q[sp_q[5:0]] <= push_dat;
    end
  end

endmodule

// File: tb/tb_control_partida.sv
// Directed + randomized bench for control_partida with a behavioural game model.
module tb_control_partida;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_bombas = '0;
  logic [2:0]  perim_x, perim_y;
  logic [3:0]  perim_cnt;
  logic [63:0] bombas_out, celda_revelada, celda_bandera;
  logic [6:0]  casillas_libres;
  logic [1:0]  estado_juego;
  logic        busy;

  control_partida_if mif ();

  control_partida #(
    .MAX_BOMBAS  (16),
    .LFSR_SEMILLA(8'hA5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_bombas     (num_bombas),
    .mov            (mif),
    .perim_x        (perim_x),
    .perim_y        (perim_y),
    .perim_cnt      (perim_cnt),
    .bombas_out     (bombas_out),
    .celda_revelada (celda_revelada),
    .celda_bandera  (celda_bandera),
    .casillas_libres(casillas_libres),
    .estado_juego   (estado_juego),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Game model
  logic [63:0] m_bomb = '0, m_rev = '0, m_flag = '0;
  int          m_libres = 0;
  int          m_estado = 0;
  logic [7:0]  ref_lfsr;

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always @(posedge clk) ref_lfsr <= rst ? 8'hA5 : lstep(ref_lfsr);

  function automatic int nbr_cnt(input int x, input int y, input logic [63:0] b);
    int n = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
          if (b[(x + dx) * 8 + y + dy]) n++;
    return n;
  endfunction

  // Perimeter datapath model driven from the bench's own bomb map.
  always_comb perim_cnt = 4'(nbr_cnt(int'(perim_x), int'(perim_y), m_bomb));

  function automatic logic [63:0] place(input logic [7:0] l0, input int n);
    logic [63:0] s = '0;
    int c = 0;
    logic [7:0] l = l0;
    while (c < n) begin
      if (!s[l[5:0]]) begin
        s[l[5:0]] = 1'b1;
        c++;
      end
      l = lstep(l);
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(input int n);
    int nc;
    nc = (n == 0) ? 1 : (n > 16) ? 16 : n;
    m_bomb   = place(ref_lfsr, nc);
    m_rev    = '0;
    m_flag   = '0;
    m_libres = 64 - nc;
    m_estado = 1;
  endtask

  task automatic model_reset();
    m_bomb = '0; m_rev = '0; m_flag = '0; m_libres = 0; m_estado = 0;
  endtask

  task automatic flood(input int i);
    int q[$];
    logic [63:0] seen;
    int c, nx, ny, j;
    seen = '0;
    seen[i] = 1'b1;
    q.push_back(i);
    while (q.size() > 0) begin
      c = q.pop_front();
      if (!m_flag[c]) begin
        m_rev[c] = 1'b1;
        m_libres--;
        if (nbr_cnt(c / 8, c % 8, m_bomb) == 0) begin
          for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++) begin
              nx = c / 8 + dx;
              ny = c % 8 + dy;
              if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
                j = nx * 8 + ny;
                if (!m_rev[j] && !m_flag[j] && !seen[j]) begin
                  seen[j] = 1'b1;
                  q.push_back(j);
                end
              end
            end
        end
      end
    end
  endtask

  task automatic model_move(input int tipo, input int x, input int y);
    int i;
    i = x * 8 + y;
    if (m_estado == 1) begin
      if (tipo == 2) begin
        if (!m_rev[i]) m_flag[i] = ~m_flag[i];
      end else if (tipo == 1 && !m_flag[i] && !m_rev[i]) begin
        if (m_bomb[i]) begin
          m_rev[i] = 1'b1;
          m_estado = 3;
        end else begin
          flood(i);
          if (m_libres == 0) m_estado = 2;
        end
      end
    end
  endtask

  task automatic chk_game(input string tag);
    chk({tag, ":bombs"}, bombas_out, m_bomb);
    chk({tag, ":rev"}, celda_revelada, m_rev);
    chk({tag, ":flag"}, celda_bandera, m_flag);
    chk({tag, ":libres"}, 64'(casillas_libres), 64'(m_libres));
    chk({tag, ":estado"}, 64'(estado_juego), 64'(m_estado));
    chk({tag, ":ready"}, 64'(mif.mov_ready), 64'(m_estado == 1));
    chk({tag, ":busy"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_done();
    int c = 0;
    while (mif.mov_ready !== 1'b1 && estado_juego < 2'd2 && c < 2000) begin
      tick();
      c++;
    end
  endtask

  task automatic do_start(input string tag, input int n);
    start = 1'b1;
    num_bombas = 6'(n);
    tick();
    start = 1'b0;
    model_start(n);
    chk({tag, ":busy_colocar"}, 64'(busy), 64'(1));
  endtask

  task automatic drive_move(input int tipo, input int x, input int y);
    mif.mov_valid = 1'b1;
    mif.mov_tipo  = 2'(tipo);
    mif.pos_x     = 3'(x);
    mif.pos_y     = 3'(y);
    tick();
    mif.mov_valid = 1'b0;
  endtask

  task automatic do_move(input string tag, input int tipo, input int x, input int y);
    chk({tag, ":ready_in"}, 64'(mif.mov_ready), 64'(1));
    drive_move(tipo, x, y);
    model_move(tipo, x, y);
    wait_done();
    chk_game(tag);
  endtask

  function automatic int find_cell(input logic [63:0] b, input int want);
    // want >= 0: safe cell with that count; want < 0: any safe nonzero cell
    for (int i = 0; i < 64; i++)
      if (!b[i]) begin
        if (want >= 0 && nbr_cnt(i / 8, i % 8, b) == want) return i;
        if (want < 0 && nbr_cnt(i / 8, i % 8, b) != 0) return i;
      end
    return -1;
  endfunction

  initial begin
    int ci, bi;
    mif.mov_valid = 1'b0;
    mif.mov_tipo  = '0;
    mif.pos_x     = '0;
    mif.pos_y     = '0;

    // Reset values
    tick(); tick(); tick();
    chk("rst:bombs", bombas_out, 64'd0);
    chk("rst:rev", celda_revelada, 64'd0);
    chk("rst:flag", celda_bandera, 64'd0);
    chk("rst:libres", 64'(casillas_libres), 64'd0);
    chk("rst:estado", 64'(estado_juego), 64'd0);
    chk("rst:ready", 64'(mif.mov_ready), 64'd0);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:perim", 64'({perim_x, perim_y}), 64'd0);
    rst = 1'b0;
    tick(); tick();

    // Ten bombs
    do_start("g10", 10);
    wait_done();
    chk_game("g10");
    chk("g10:popcount", 64'($countones(bombas_out)), 64'd10);
    chk("g10:libres54", 64'(casillas_libres), 64'd54);

    // Nonzero reveal latency
    ci = find_cell(m_bomb, 3);
    if (ci < 0) ci = find_cell(m_bomb, -1);
    drive_move(1, ci / 8, ci % 8);
    chk("lat:T_rev", 64'(celda_revelada[ci]), 64'd0);
    chk("lat:T_ready", 64'(mif.mov_ready), 64'd0);
    tick();
    chk("lat:T1_rev", 64'(celda_revelada[ci]), 64'd1);
    chk("lat:T1_libres", 64'(casillas_libres), 64'd53);
    chk("lat:T1_ready", 64'(mif.mov_ready), 64'd0);
    tick();
    chk("lat:T2_ready", 64'(mif.mov_ready), 64'd1);
    model_move(1, ci / 8, ci % 8);
    chk_game("lat");
    do_move("rereveal", 1, ci / 8, ci % 8);

    // Clamp low, start ignored while placing, clamp high
    do_start("g0", 0);
    start = 1'b1;
    num_bombas = 6'd40;
    tick();
    start = 1'b0;
    wait_done();
    chk_game("g0");
    chk("g0:popcount", 64'($countones(bombas_out)), 64'd1);
    do_start("g40", 40);
    wait_done();
    chk_game("g40");
    chk("g40:popcount", 64'($countones(bombas_out)), 64'd16);

    // Flags and a losing reveal
    do_start("gf", 10);
    wait_done();
    drive_move(2, 2, 3);
    chk("flag:set", 64'(celda_bandera[19]), 64'd1);
    chk("flag:ready", 64'(mif.mov_ready), 64'd1);
    model_move(2, 2, 3);
    do_move("flag:reveal", 1, 2, 3);
    chk("flag:not_rev", 64'(celda_revelada[19]), 64'd0);
    do_move("flag:clear", 2, 2, 3);
    chk("flag:cleared", 64'(celda_bandera[19]), 64'd0);
    bi = 0;
    while (!m_bomb[bi]) bi++;
    do_move("boom", 1, bi / 8, bi % 8);
    chk("boom:estado", 64'(estado_juego), 64'd3);
    chk("boom:rev", 64'(celda_revelada[bi]), 64'd1);

    // start and move in the same cycle
    do_start("gs", 8);
    wait_done();
    start = 1'b1;
    num_bombas = 6'd5;
    mif.mov_valid = 1'b1;
    mif.mov_tipo = 2'd1;
    mif.pos_x = 3'd0;
    mif.pos_y = 3'd0;
    tick();
    start = 1'b0;
    mif.mov_valid = 1'b0;
    model_start(5);
    chk("both:busy", 64'(busy), 64'd1);
    chk("both:rev", celda_revelada, 64'd0);
    wait_done();
    chk_game("both");

    // Single bomb, full flood to a win
    do_start("g1", 1);
    wait_done();
    ci = find_cell(m_bomb, 0);
    do_move("flood", 1, ci / 8, ci % 8);
    chk("flood:popcount", 64'($countones(celda_revelada)), 64'd63);
    chk("flood:bomb_hidden", celda_revelada & bombas_out, 64'd0);
    chk("flood:estado", 64'(estado_juego), 64'd2);

    // Reset in the middle of a flood
    do_start("gr", 1);
    wait_done();
    ci = find_cell(m_bomb, 0);
    drive_move(1, ci / 8, ci % 8);
    tick();
    chk("midrst:busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    model_reset();
    chk("midrst:rev", celda_revelada, 64'd0);
    chk("midrst:bombs", bombas_out, 64'd0);
    chk("midrst:libres", 64'(casillas_libres), 64'd0);
    chk("midrst:estado", 64'(estado_juego), 64'd0);
    chk("midrst:ready", 64'(mif.mov_ready), 64'd0);
    chk("midrst:busy0", 64'(busy), 64'd0);
    chk("midrst:perim", 64'({perim_x, perim_y}), 64'd0);
    rst = 1'b0;
    tick();

    // Randomized games
    for (int g = 0; g < 4; g++) begin
      do_start("rnd", int'($urandom_range(0, 63)));
      wait_done();
      chk_game("rnd_start");
      for (int m = 0; m < 40; m++) begin
        int r, t;
        if (m_estado != 1) break;
        r = int'($urandom_range(0, 9));
        t = (r < 6) ? 1 : (r < 8) ? 2 : (r == 8) ? 0 : 3;
        do_move("rnd_move", t, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
